// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the CORDIC output path.
//   - IN_W_DEF / OUT_W_DEF / SHIFT_W_DEF : default operand, result and shift widths
//   - SHIFT_LEFT / SHIFT_RIGHT           : encodings of the type_shift input
//   - OUT_MAX / OUT_MIN                  : saturation limits at the default result width
package cordic_pkg;

  localparam int IN_W_DEF    = 40;
  localparam int OUT_W_DEF   = 32;
  localparam int SHIFT_W_DEF = 6;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  localparam logic [OUT_W_DEF-1:0] OUT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic [OUT_W_DEF-1:0] OUT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

endpackage

// File: rtl/cordic_round_sat.sv
// cordic_round_sat
//   Combinational round-half-up and saturate of a shifted CORDIC value.
//   Ports:
//     shifted  in  IN_W+1  signed shifted value (guard bits in the low IN_W-OUT_W bits)
//     ovf      in  1       value already overflowed during the shift
//     ovf_neg  in  1       direction of that overflow (1 = toward -inf)
//     result   out OUT_W   rounded, saturated result
//     sat      out 1       result was clamped
//   IN_W - OUT_W must be at least 1 (there is always a rounding bit).
module cordic_round_sat
  import cordic_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W:0]    shifted,
  input  logic             ovf,
  input  logic             ovf_neg,
  output logic [OUT_W-1:0] result,
  output logic             sat
);

  localparam int GUARD_W = IN_W - OUT_W;
  // One bit wider than the shifted value so the rounding carry is never lost.
  localparam int SUM_W   = IN_W + 2;
  localparam int Q_W     = SUM_W - GUARD_W;  // OUT_W + 2

  localparam logic [OUT_W-1:0] SAT_HI =
    (OUT_W == OUT_W_DEF) ? OUT_W'(OUT_MAX) : {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_LO =
    (OUT_W == OUT_W_DEF) ? OUT_W'(OUT_MIN) : {1'b1, {(OUT_W-1){1'b0}}};

  logic [SUM_W-1:0] sum;
  logic [Q_W-1:0]   q;
  logic             pos_over;
  logic             neg_over;

  always_comb begin
    sum = {shifted[IN_W], shifted} + (SUM_W'(1) << (GUARD_W - 1));
    q   = sum[SUM_W-1:GUARD_W];
    // q fits the output iff its top three bits are identical.
    pos_over = !q[Q_W-1] && (|q[Q_W-2:OUT_W-1]);
    neg_over =  q[Q_W-1] && !(&q[Q_W-2:OUT_W-1]);

    result = q[OUT_W-1:0];
    sat    = 1'b0;
    if (ovf) begin
      result = ovf_neg ? SAT_LO : SAT_HI;
      sat    = 1'b1;
    end else if (pos_over) begin
      result = SAT_HI;
      sat    = 1'b1;
    end else if (neg_over) begin
      result = SAT_LO;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/cordic_denorm_pipe.sv
// cordic_denorm_pipe
//   Two-stage denormalisation: S1 undoes the normalisation shift, S2 rounds
//   away the guard bits and saturates. Valid/ready on both sides, capacity 2.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     in_valid/ready  input handshake (in_ready depends combinationally on out_ready)
//     operand         signed IN_W input value
//     shift_amt       shift distance 0 .. 2^SHIFT_W-1
//     type_shift      SHIFT_LEFT or SHIFT_RIGHT (arithmetic)
//     out_valid/ready output handshake
//     denorm_operand  rounded, saturated OUT_W result
//     sat             result was clamped
module cordic_denorm_pipe
  import cordic_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    operand,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic               type_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   denorm_operand,
  output logic               sat
);

  // Wide enough to hold any left-shifted operand without losing bits, so the
  // overflow check can look at everything above the IN_W+1 result window.
  localparam int EXT_W = IN_W + (1 << SHIFT_W);

  // ---------------- S1: shift ----------------
  logic [EXT_W-1:0] ext_op;
  logic [EXT_W-1:0] lsh;
  logic [IN_W:0]    rsh;
  logic [IN_W:0]    shift_res;
  logic             shift_ovf;

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W:0]    s1_val_q,   s1_val_d;
  logic             s1_ovf_q,   s1_ovf_d;
  logic             s1_neg_q,   s1_neg_d;

  // ---------------- S2: round / saturate ----------------
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] res_q,      res_d;
  logic             sat_q,      sat_d;
  logic [OUT_W-1:0] rs_result;
  logic             rs_sat;

  logic             s1_adv;
  logic             s2_adv;

  always_comb begin
    ext_op = {{(EXT_W-IN_W){operand[IN_W-1]}}, operand};
    lsh    = ext_op << shift_amt;
    rsh    = $signed({operand[IN_W-1], operand}) >>> shift_amt;

    shift_res = '0;
    shift_ovf = 1'b0;
    case (type_shift)
      SHIFT_LEFT: begin
        shift_res = lsh[IN_W:0];
        // Everything from bit IN_W upward must be a copy of the sign.
        shift_ovf = !((&lsh[EXT_W-1:IN_W]) || !(|lsh[EXT_W-1:IN_W]));
      end
      SHIFT_RIGHT: begin
        shift_res = rsh;
      end
      default: begin
        shift_res = '0;
      end
    endcase
  end

  cordic_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .shifted (s1_val_q),
    .ovf     (s1_ovf_q),
    .ovf_neg (s1_neg_q),
    .result  (rs_result),
    .sat     (rs_sat)
  );

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;

    s1_valid_d = s1_valid_q;
    s1_val_d   = s1_val_q;
    s1_ovf_d   = s1_ovf_q;
    s1_neg_d   = s1_neg_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_val_d = shift_res;
        s1_ovf_d = shift_ovf;
        s1_neg_d = operand[IN_W-1];
      end
    end

    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    sat_d      = sat_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d = rs_result;
        sat_d = rs_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_val_q   <= '0;
      s1_ovf_q   <= 1'b0;
      s1_neg_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_val_q   <= s1_val_d;
      s1_ovf_q   <= s1_ovf_d;
      s1_neg_q   <= s1_neg_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      sat_q      <= sat_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign denorm_operand = res_q;
  assign sat            = sat_q;

endmodule
